// File: rtl/bc_fill_pkg.sv
// Shared types and helpers for the box-count fill stage and its coarse-grid neighbour.
// Combinational helpers only; no state.
// No handshake; pure definitions.
package bc_fill_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FILL  = 3'd2,
        FLUSH = 3'd3,
        SQG   = 3'd4
    } fill_state_t;

    // Packs {bx, lvl, by}; callers cast the result down to 2*box_idx+1 bits.
    function automatic logic [31:0] bc_addr(input logic [15:0] bx,
                                            input logic        lvl,
                                            input logic [15:0] by,
                                            input int          box_idx);
        logic [31:0] a;
        a = ({16'd0, bx} << (box_idx + 1)) | ({31'd0, lvl} << box_idx) | {16'd0, by};
        return a;
    endfunction

    // Unsigned add that clamps at 2^data_len-1 instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          data_len);
        logic [32:0] s;
        logic [32:0] mx;
        s  = {1'b0, a} + {1'b0, b};
        mx = (33'd1 << data_len) - 33'd1;
        return (s > mx) ? mx[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/bc_fill_if.sv
// Pixel stream, box-count RAM port and control signals of the fill stage.
// Wires only; no latency.
// pix_valid/pix_ready handshake on the pixel stream; RAM side has no backpressure.
interface bc_fill_if #(
    parameter int BOX_IDX  = 3,
    parameter int PIX_LEN  = 1,
    parameter int DATA_LEN = 8
);
    localparam int AW = 2 * BOX_IDX + 1;

    logic                start;
    logic                pix_valid;
    logic [PIX_LEN-1:0]  pix;
    logic                pix_ready;
    logic                BC_mode;
    logic [AW-1:0]       BC_rd_addr;
    logic [DATA_LEN-1:0] BC_rd_data;
    logic                wen_fill;
    logic [AW-1:0]       BC_wr_addr;
    logic [DATA_LEN-1:0] BC_wr_data;
    logic                done;

    modport master (
        output start, pix_valid, pix, BC_rd_data,
        input  pix_ready, BC_mode, BC_rd_addr, wen_fill, BC_wr_addr, BC_wr_data, done
    );

    modport slave (
        input  start, pix_valid, pix, BC_rd_data,
        output pix_ready, BC_mode, BC_rd_addr, wen_fill, BC_wr_addr, BC_wr_data, done
    );
endinterface

// File: rtl/bc_run_acc.sv
// Run accumulator: sums pixels of one row-run inside a box and forms the RAM update word.
// Run sum registered on the last pixel; write data is combinational from RAM read data next cycle.
// No backpressure; acc_en is the upstream accept strobe.
module bc_run_acc
    import bc_fill_pkg::*;
#(
    parameter int PIX_LEN  = 1,
    parameter int DATA_LEN = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                clr,
    input  logic                acc_en,
    input  logic                run_last,
    input  logic [PIX_LEN-1:0]  pix,
    input  logic [DATA_LEN-1:0] rd_data,
    output logic [DATA_LEN-1:0] wr_data
);

    logic [DATA_LEN-1:0] acc;
    logic [DATA_LEN-1:0] acc_next;
    logic [DATA_LEN-1:0] run_sum_q;

    // Running sum including the current pixel, clamped.
    always_comb begin
        acc_next = DATA_LEN'(sat_add(32'(acc), 32'(pix), DATA_LEN));
        wr_data  = DATA_LEN'(sat_add(32'(rd_data), 32'(run_sum_q), DATA_LEN));
    end

    // Accumulate within a run; hand the finished run to the write stage and restart.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc       <= '0;
            run_sum_q <= '0;
        end else if (clr) begin
            acc       <= '0;
        end else if (acc_en) begin
            if (run_last) begin
                run_sum_q <= acc_next;
                acc       <= '0;
            end else begin
                acc       <= acc_next;
            end
        end
    end

endmodule

// File: rtl/bc_fill.sv
// Clears level 0 of the box-count RAM, then accumulates a raster pixel stream into finest-grid boxes.
// One pixel/cycle; each run's read-modify-write completes one cycle after its last pixel.
// pix_ready high only in FILL, never stalls there; start ignored outside IDLE/SQG.
module bc_fill
    import bc_fill_pkg::*;
#(
    parameter int BOX_IDX  = 3,
    parameter int IMG_IDX  = 5,
    parameter int PIX_LEN  = 1,
    parameter int DATA_LEN = 8
) (
    input logic      CLK,
    input logic      RST,
    bc_fill_if.slave bus
);

    localparam int AW         = 2 * BOX_IDX + 1;
    localparam int CW         = 2 * IMG_IDX;
    localparam int BW         = 2 * BOX_IDX;
    localparam int SEG_W      = IMG_IDX - BOX_IDX;
    localparam int SEG_MASK_I = (1 << SEG_W) - 1;
    localparam logic [IMG_IDX-1:0] SEG_MASK = SEG_MASK_I[IMG_IDX-1:0];

    fill_state_t         state, state_nxt;
    logic [CW-1:0]       pix_cnt;
    logic [BW-1:0]       clr_cnt;
    logic                wr_pend;
    logic [AW-1:0]       wr_addr_q;
    logic                done_q;

    logic [IMG_IDX-1:0]  x, y;
    logic [BOX_IDX-1:0]  bx, by;
    logic [AW-1:0]       fill_addr, clr_addr;
    logic                accept, run_last, last_pix;
    logic [DATA_LEN-1:0] acc_wr_data;

    // Pixel coordinates, box addresses and accept qualifiers.
    always_comb begin
        x         = pix_cnt[IMG_IDX-1:0];
        y         = pix_cnt[CW-1:IMG_IDX];
        bx        = x[IMG_IDX-1 -: BOX_IDX];
        by        = y[IMG_IDX-1 -: BOX_IDX];
        fill_addr = AW'(bc_addr(16'(bx), 1'b0, 16'(by), BOX_IDX));
        clr_addr  = AW'(bc_addr(16'(clr_cnt[BW-1:BOX_IDX]), 1'b0, 16'(clr_cnt[BOX_IDX-1:0]), BOX_IDX));
        accept    = bus.pix_valid && (state == FILL);
        run_last  = ((x & SEG_MASK) == SEG_MASK);
        last_pix  = &pix_cnt;
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and RAM/handshake outputs.
    always_comb begin
        state_nxt      = state;
        bus.pix_ready  = 1'b0;
        bus.BC_mode    = 1'b1;
        bus.BC_rd_addr = '0;
        bus.wen_fill   = 1'b0;
        bus.BC_wr_addr = '0;
        bus.BC_wr_data = '0;
        bus.done       = done_q;

        case (state)
            IDLE:  if (bus.start) state_nxt = CLEAR;
            CLEAR: if (&clr_cnt) state_nxt = FILL;
            FILL:  if (accept && last_pix) state_nxt = FLUSH;
            FLUSH: state_nxt = SQG;
            SQG:   if (bus.start) state_nxt = CLEAR;
            default: state_nxt = IDLE;
        endcase

        if (state == FILL) bus.pix_ready = 1'b1;
        if (state == SQG)  bus.BC_mode   = 1'b0;
        if (accept && run_last) bus.BC_rd_addr = fill_addr;

        if (state == CLEAR) begin
            bus.wen_fill   = 1'b1;
            bus.BC_wr_addr = clr_addr;
        end else if (wr_pend) begin
            bus.wen_fill   = 1'b1;
            bus.BC_wr_addr = wr_addr_q;
            bus.BC_wr_data = acc_wr_data;
        end
    end

    // Clear walker, pixel counter, pending-write tracking and done pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clr_cnt   <= '0;
            pix_cnt   <= '0;
            wr_pend   <= 1'b0;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
        end else begin
            clr_cnt <= (state == CLEAR) ? clr_cnt + 1'b1 : '0;
            if (state == CLEAR)  pix_cnt <= '0;
            else if (accept)     pix_cnt <= pix_cnt + 1'b1;
            wr_pend <= accept && run_last;
            if (accept && run_last) wr_addr_q <= fill_addr;
            done_q  <= (state == FLUSH);
        end
    end

    bc_run_acc #(
        .PIX_LEN (PIX_LEN),
        .DATA_LEN(DATA_LEN)
    ) u_acc (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (state == CLEAR),
        .acc_en  (accept),
        .run_last(run_last),
        .pix     (bus.pix),
        .rd_data (bus.BC_rd_data),
        .wr_data (acc_wr_data)
    );

endmodule
